// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tracks in-flight register writes; drives the RAW stall and
//            EX-stage forward selects from ID.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
  parameter int AW    = 5,
  parameter int NREG  = 32,
  parameter int DEPTH = 3,
  parameter int LW    = 2,
  parameter int SW_   = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           hold,
  input  logic           issue_valid,
  input  logic [AW-1:0]  issue_rs,
  input  logic [AW-1:0]  issue_rt,
  input  logic           rs_used,
  input  logic           rt_used,
  input  logic [AW-1:0]  issue_rd,
  input  logic           issue_wr,
  input  logic [LW-1:0]  issue_lat,
  output logic           stall,
  output logic [SW_-1:0] fwd_rs,
  output logic [SW_-1:0] fwd_rt,
  output logic           busy,
  output logic [15:0]    stall_count
);

  localparam int c_agw = $clog2(DEPTH + 1);

  logic [NREG-1:0]  r_pend;
  logic [c_agw-1:0] r_age [NREG];
  logic [c_agw-1:0] r_lat [NREG];
  logic             r_busy;
  logic [15:0]      r_stall_count;

  logic [NREG-1:0]  w_pend_nxt;
  logic [c_agw-1:0] w_age_nxt [NREG];
  logic [c_agw-1:0] w_lat_nxt [NREG];
  logic [c_agw-1:0] w_lat_eff;
  logic             w_rs_hit;
  logic             w_rt_hit;
  logic             w_rs_wait;
  logic             w_rt_wait;
  logic             w_alloc;

  always_comb begin
    w_lat_eff = c_agw'(issue_lat);
    if (issue_lat == '0) begin
      w_lat_eff = c_agw'(1);
    end else if (int'(issue_lat) > DEPTH - 1) begin
      w_lat_eff = c_agw'(DEPTH - 1);
    end
  end

  // Register 0 is never tracked, so a hit always needs a nonzero source.
  assign w_rs_hit  = rs_used && (issue_rs != '0) && r_pend[issue_rs];
  assign w_rt_hit  = rt_used && (issue_rt != '0) && r_pend[issue_rt];
  assign w_rs_wait = w_rs_hit && (r_age[issue_rs] < r_lat[issue_rs]);
  assign w_rt_wait = w_rt_hit && (r_age[issue_rt] < r_lat[issue_rt]);

  assign stall  = issue_valid && (w_rs_wait || w_rt_wait);
  assign fwd_rs = w_rs_hit ? SW_'(r_age[issue_rs]) : '0;
  assign fwd_rt = w_rt_hit ? SW_'(r_age[issue_rt]) : '0;

  assign w_alloc = issue_valid && !stall && issue_wr && (issue_rd != '0);

  // A new writer replaces the old entry outright, even one retiring this edge.
  always_comb begin
    w_pend_nxt = r_pend;
    w_age_nxt  = r_age;
    w_lat_nxt  = r_lat;
    for (int i = 1; i < NREG; i++) begin
      if (w_alloc && (issue_rd == AW'(i))) begin
        w_pend_nxt[i] = 1'b1;
        w_age_nxt[i]  = c_agw'(1);
        w_lat_nxt[i]  = w_lat_eff;
      end else if (r_pend[i]) begin
        if (r_age[i] == c_agw'(DEPTH - 1)) begin
          w_pend_nxt[i] = 1'b0;
          w_age_nxt[i]  = '0;
        end else begin
          w_age_nxt[i] = r_age[i] + c_agw'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend        <= '0;
      r_age         <= '{default: '0};
      r_lat         <= '{default: '0};
      r_busy        <= 1'b0;
      r_stall_count <= '0;
    end else if (!hold) begin
      r_pend <= w_pend_nxt;
      r_age  <= w_age_nxt;
      r_lat  <= w_lat_nxt;
      r_busy <= |w_pend_nxt;
      if (stall && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign busy        = r_busy;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed and randomized checks of hazard_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, hold, issue_valid, rs_used, rt_used, issue_wr;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic [1:0]  issue_lat;
  logic        stall, busy;
  logic [1:0]  fwd_rs, fwd_rt;
  logic [15:0] stall_count;

  logic        s_hold, s_valid, s_rs_used, s_rt_used, s_wr;
  logic [4:0]  s_rs, s_rt, s_rd, s_lat;
  logic        s_stall, s_busy;
  logic [4:0]  s_fwd_rs, s_fwd_rt;
  logic [15:0] s_count;

  int n_pass  = 0;
  int n_total = 0;

  hazard_scoreboard dut (
    .clock(clock), .reset(reset), .hold(hold), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .rs_used(rs_used), .rt_used(rt_used),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_lat(issue_lat),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .busy(busy),
    .stall_count(stall_count)
  );

  hazard_scoreboard #(.AW(5), .NREG(32), .DEPTH(32), .LW(5), .SW_(5)) u_sat (
    .clock(clock), .reset(reset), .hold(s_hold), .issue_valid(s_valid),
    .issue_rs(s_rs), .issue_rt(s_rt), .rs_used(s_rs_used), .rt_used(s_rt_used),
    .issue_rd(s_rd), .issue_wr(s_wr), .issue_lat(s_lat),
    .stall(s_stall), .fwd_rs(s_fwd_rs), .fwd_rt(s_fwd_rt), .busy(s_busy),
    .stall_count(s_count)
  );

  // Reference model: each register remembers the tick its newest writer issued.
  int m_tick;
  int m_wt [32];
  int m_wl [32];
  bit m_has [32];
  int m_count;

  function automatic int eff_lat(int l);
    if (l == 0) return 1;
    if (l > DEPTH - 1) return DEPTH - 1;
    return l;
  endfunction

  function automatic bit live(int r);
    return (r != 0) && m_has[r] && ((m_tick - m_wt[r]) < DEPTH);
  endfunction

  function automatic bit src_wait(int r, bit u);
    return u && live(r) && ((m_tick - m_wt[r]) < m_wl[r]);
  endfunction

  function automatic int src_fwd(int r, bit u);
    return (u && live(r)) ? (m_tick - m_wt[r]) : 0;
  endfunction

  function automatic bit m_stall();
    return issue_valid && (src_wait(int'(issue_rs), rs_used) || src_wait(int'(issue_rt), rt_used));
  endfunction

  function automatic bit m_busy();
    for (int r = 1; r < 32; r++) if (live(r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_tick  = 0;
    m_count = 0;
    for (int r = 0; r < 32; r++) m_has[r] = 1'b0;
  endtask

  task automatic step();
    bit s;
    s = m_stall();
    if (!hold) begin
      if (s && m_count < 65535) m_count++;
      if (issue_valid && !s && issue_wr && issue_rd != 5'd0) begin
        m_has[int'(issue_rd)] = 1'b1;
        m_wt[int'(issue_rd)]  = m_tick;
        m_wl[int'(issue_rd)]  = eff_lat(int'(issue_lat));
      end
      m_tick++;
    end
    @(posedge clock);
  endtask

  task automatic drive(input bit v, input int rs, input bit ru, input int rt, input bit tu,
                       input int rd, input bit wr, input int lat, input bit h);
    @(negedge clock);
    issue_valid = v;  issue_rs = 5'(rs); rs_used = ru; issue_rt = 5'(rt); rt_used = tu;
    issue_rd = 5'(rd); issue_wr = wr;    issue_lat = 2'(lat); hold = h;
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rs = 0; rs_used = 0; issue_rt = 0; rt_used = 0;
    issue_rd = 0; issue_wr = 0; issue_lat = 0; hold = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    #1;
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_rs, fwd_rt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (stall_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", stall_count); else n_pass++;
  endtask

  task automatic test_alu_forward();
    do_reset();
    drive(1, 1, 1, 2, 1, 3, 1, 1, 0);
    n_total++; if (stall !== 1'b0) $display("FAIL alu_first_stall: got %b want 0", stall); else n_pass++;
    step();
    drive(1, 3, 1, 3, 1, 4, 1, 1, 0);
    n_total++; if (stall !== 1'b0) $display("FAIL alu_n1_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (fwd_rs !== 2'd1 || fwd_rt !== 2'd1) $display("FAIL alu_n1_fwd: got %0d/%0d want 1/1", fwd_rs, fwd_rt); else n_pass++;
    step();
    drive(1, 3, 1, 0, 1, 5, 1, 1, 0);
    n_total++; if (fwd_rs !== 2'd2 || fwd_rt !== 2'd0) $display("FAIL alu_n2_fwd: got %0d/%0d want 2/0", fwd_rs, fwd_rt); else n_pass++;
    step();
    drive(1, 3, 1, 0, 0, 0, 0, 1, 0);
    n_total++; if (fwd_rs !== 2'd0 || stall !== 1'b0) $display("FAIL alu_n3_fwd: got fwd %0d stall %b want 0/0", fwd_rs, stall); else n_pass++;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_total++; if (busy !== 1'b1) $display("FAIL alu_busy_pending: got %b want 1", busy); else n_pass++;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_total++; if (busy !== 1'b0) $display("FAIL alu_busy_retired: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_load_stall();
    do_reset();
    drive(1, 1, 1, 0, 0, 2, 1, 2, 0);
    step();
    drive(1, 2, 1, 0, 0, 6, 1, 1, 0);
    n_total++; if (stall !== 1'b1) $display("FAIL load_stall: got %b want 1", stall); else n_pass++;
    step();
    drive(1, 2, 1, 0, 0, 6, 1, 1, 0);
    n_total++; if (stall !== 1'b0) $display("FAIL load_retry_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (fwd_rs !== 2'd2) $display("FAIL load_retry_fwd: got %0d want 2", fwd_rs); else n_pass++;
    n_total++; if (stall_count !== 16'd1) $display("FAIL load_count: got %0d want 1", stall_count); else n_pass++;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_total++; if (stall_count !== 16'd1) $display("FAIL load_count_after: got %0d want 1", stall_count); else n_pass++;
  endtask

  task automatic test_waw();
    do_reset();
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0);
    step();
    drive(1, 1, 0, 0, 0, 7, 1, 2, 0);
    n_total++; if (stall !== 1'b0) $display("FAIL waw_load_issue: got %b want 0", stall); else n_pass++;
    step();
    drive(1, 7, 1, 7, 1, 8, 1, 1, 0);
    n_total++; if (stall !== 1'b1) $display("FAIL waw_stall: got %b want 1", stall); else n_pass++;
    step();
    drive(1, 7, 1, 7, 1, 8, 1, 1, 0);
    n_total++; if (stall !== 1'b0 || fwd_rs !== 2'd2 || fwd_rt !== 2'd2)
      $display("FAIL waw_retry: got stall %b fwd %0d/%0d want 0 2/2", stall, fwd_rs, fwd_rt); else n_pass++;
  endtask

  task automatic test_r0();
    do_reset();
    drive(1, 0, 1, 0, 1, 0, 1, 1, 0);
    n_total++; if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0)
      $display("FAIL r0_write: got stall %b fwd %0d/%0d want 0 0/0", stall, fwd_rs, fwd_rt); else n_pass++;
    step();
    drive(1, 0, 1, 0, 1, 9, 0, 1, 0);
    n_total++; if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0)
      $display("FAIL r0_read: got stall %b fwd %0d/%0d want 0 0/0", stall, fwd_rs, fwd_rt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL r0_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    drive(1, 1, 1, 0, 0, 2, 1, 2, 0);
    step();
    drive(1, 2, 1, 0, 0, 6, 1, 1, 1);
    n_total++; if (stall !== 1'b1) $display("FAIL hold_stall_initial: got %b want 1", stall); else n_pass++;
    repeat (5) step();
    drive(1, 2, 1, 0, 0, 6, 1, 1, 1);
    n_total++; if (stall !== 1'b1) $display("FAIL hold_stall_kept: got %b want 1", stall); else n_pass++;
    n_total++; if (stall_count !== 16'd0) $display("FAIL hold_count: got %0d want 0", stall_count); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL hold_busy: got %b want 1", busy); else n_pass++;
    step();
    drive(1, 2, 1, 0, 0, 6, 1, 1, 0);
    n_total++; if (stall !== 1'b1) $display("FAIL hold_release_stall: got %b want 1", stall); else n_pass++;
    step();
    drive(1, 2, 1, 0, 0, 6, 1, 1, 0);
    n_total++; if (stall !== 1'b0 || fwd_rs !== 2'd2 || stall_count !== 16'd1)
      $display("FAIL hold_resume: got stall %b fwd %0d count %0d want 0 2 1", stall, fwd_rs, stall_count); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 1, 1, 0, 0, 2, 1, 2, 0);
    step();
    drive(1, 2, 1, 0, 0, 6, 1, 1, 0);
    n_total++; if (stall !== 1'b1) $display("FAIL midrst_pre_stall: got %b want 1", stall); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_total++; if (stall !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_async: got stall %b busy %b want 0 0", stall, busy); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    drive(1, 2, 1, 0, 0, 0, 0, 1, 0);
    n_total++; if (stall !== 1'b0 || fwd_rs !== 2'd0)
      $display("FAIL midrst_after: got stall %b fwd %0d want 0 0", stall, fwd_rs); else n_pass++;
  endtask

  task automatic test_random();
    bit es;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom % 2),
            $urandom_range(0, 7), 1'($urandom % 2), $urandom_range(0, 7), 1'($urandom % 2),
            $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      es = m_stall();
      n_total++; if (stall !== es) $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, es); else n_pass++;
      if (!es) begin
        n_total++; if (int'(fwd_rs) != src_fwd(int'(issue_rs), rs_used))
          $display("FAIL rnd_fwd_rs c%0d: got %0d want %0d", c, fwd_rs, src_fwd(int'(issue_rs), rs_used)); else n_pass++;
        n_total++; if (int'(fwd_rt) != src_fwd(int'(issue_rt), rt_used))
          $display("FAIL rnd_fwd_rt c%0d: got %0d want %0d", c, fwd_rt, src_fwd(int'(issue_rt), rt_used)); else n_pass++;
      end
      n_total++; if (busy !== m_busy()) $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_busy()); else n_pass++;
      n_total++; if (int'(stall_count) != m_count)
        $display("FAIL rnd_count c%0d: got %0d want %0d", c, stall_count, m_count); else n_pass++;
      step();
    end
  endtask

  // Self-dependent lat-31 instruction on a 32-deep instance stalls 30 of every 31 cycles.
  task automatic test_saturation();
    int sage, exp_cnt, bad;
    bit st, mid_done;
    do_reset();
    @(negedge clock);
    s_valid = 1; s_rs = 5'd1; s_rs_used = 1; s_rd = 5'd1; s_wr = 1; s_lat = 5'd31;
    #1;
    sage = 0; exp_cnt = 0; bad = 0; mid_done = 0;
    for (int c = 0; c < 72600; c++) begin
      st = (sage != 0) && (sage < 31);
      if (s_stall !== st) bad++;
      if (!mid_done && exp_cnt == 65534) begin
        mid_done = 1;
        n_total++; if (s_count !== 16'd65534) $display("FAIL sat_mid_count: got %0d want 65534", s_count); else n_pass++;
      end
      @(posedge clock);
      if (st) begin
        if (exp_cnt < 65535) exp_cnt++;
        sage++;
      end else begin
        sage = 1;
      end
      @(negedge clock);
      #1;
    end
    n_total++; if (bad != 0) $display("FAIL sat_stall_pattern: got %0d bad cycles want 0", bad); else n_pass++;
    n_total++; if (s_count !== 16'hFFFF) $display("FAIL sat_count: got %h want ffff", s_count); else n_pass++;
    s_valid = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    s_hold = 0; s_valid = 0; s_rs = 0; s_rt = 0; s_rs_used = 0; s_rt_used = 0;
    s_rd = 0; s_wr = 0; s_lat = 0;
    model_clear();
    test_reset();
    test_alu_forward();
    test_load_stall();
    test_waw();
    test_r0();
    test_hold();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
